memory_port_arbiter: RTL and testbench

- Shares one single-port memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined MIPS core.
- Sequences each access through a fixed-latency transaction and returns read data with a one-cycle done pulse.
- Drives per-requester stall outputs that the stall/flush control uses to freeze the PC, IF/ID and downstream registers.

---
 rtl/memory_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Single-port memory arbiter shared by the IF and MEM stages of the MIPS pipeline.
// Grants one fixed-latency access at a time and returns read data with a done pulse.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no access in progress, arbitrate on requests
// BUSY  | access running, cnt counts LATENCY cycles down
// DONE  | single completion cycle, owner's done high
`timescale 1ns/1ps
module memory_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              if_stall,
    output logic              dm_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_dm_q, last_dm_d;
    logic              owner_dm_q, owner_dm_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;

    logic dm_req;
    logic grant_dm;

    assign dm_req = dm_read | dm_write;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        owner_dm_d  = owner_dm_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        // DM has priority unless it took the previous grant and IF is waiting.
        grant_dm    = dm_req & (~if_req | ~last_dm_q);

        case (state_q)
            S_IDLE: begin
                if (if_req | dm_req) begin
                    state_d     = S_BUSY;
                    cnt_d       = LAT_CNT;
                    last_dm_d   = grant_dm;
                    owner_dm_d  = grant_dm;
                    ram_en_d    = 1'b1;
                    ram_we_d    = grant_dm & dm_write;
                    ram_addr_d  = grant_dm ? dm_addr : if_addr;
                    ram_wdata_d = grant_dm ? dm_wdata : '0;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = S_DONE;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    if (owner_dm_q) begin
                        dm_done_d = 1'b1;
                        if (!ram_we_q) dm_rdata_d = ram_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            last_dm_q   <= 1'b0;
            owner_dm_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            owner_dm_q  <= owner_dm_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;

    // Stalls release in the done cycle so the pipeline advances on that edge.
    assign if_stall = if_req & ~if_done_q;
    assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance at LATENCY=2, one at LATENCY=1.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
`timescale 1ns/1ps
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata, ram_rdata;

    logic [31:0] if_rdata_a, dm_rdata_a, ram_addr_a, ram_wdata_a;
    logic        if_done_a, dm_done_a, ram_en_a, ram_we_a, if_stall_a, dm_stall_a;
    logic [31:0] if_rdata_b, dm_rdata_b, ram_addr_b, ram_wdata_b;
    logic        if_done_b, dm_done_b, ram_en_b, ram_we_b, if_stall_b, dm_stall_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_if_rdata, exp_dm_rdata;

    always #5 clk = ~clk;

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_done(if_done_a),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_a), .dm_done(dm_done_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata), .if_stall(if_stall_a), .dm_stall(dm_stall_a)
    );

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_done(if_done_b),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_b), .dm_done(dm_done_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata), .if_stall(if_stall_b), .dm_stall(dm_stall_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Single uncontended access on the LATENCY=2 instance, cycles 0..4.
    task automatic do_access(input logic is_if, input logic is_wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        if_req   = is_if;
        dm_read  = !is_if && !is_wr;
        dm_write = !is_if && is_wr;
        if_addr  = addr;
        dm_addr  = addr;
        dm_wdata = wdata;
        settle();
        check_eq("acc_c0_stall", is_if ? if_stall_a : dm_stall_a, 1);
        check_eq("acc_c0_en", ram_en_a, 0);
        next_cycle();
        ram_rdata = ~rdata;
        if_addr   = addr ^ 32'hFFFF;
        dm_addr   = addr ^ 32'hFFFF;
        dm_wdata  = ~wdata;
        settle();
        check_eq("acc_c1_en", ram_en_a, 1);
        check_eq("acc_c1_we", ram_we_a, is_wr);
        check_eq("acc_c1_addr", ram_addr_a, addr);
        if (is_wr) check_eq("acc_c1_wdata", ram_wdata_a, wdata);
        next_cycle();
        ram_rdata = rdata;
        settle();
        check_eq("acc_c2_en", ram_en_a, 1);
        check_eq("acc_c2_we", ram_we_a, is_wr);
        check_eq("acc_c2_addr", ram_addr_a, addr);
        check_eq("acc_c2_stall", is_if ? if_stall_a : dm_stall_a, 1);
        next_cycle();
        if (is_if) exp_if_rdata = rdata;
        else if (!is_wr) exp_dm_rdata = rdata;
        check_eq("acc_c3_if_done", if_done_a, is_if);
        check_eq("acc_c3_dm_done", dm_done_a, !is_if);
        check_eq("acc_c3_stall", is_if ? if_stall_a : dm_stall_a, 0);
        check_eq("acc_c3_en", ram_en_a, 0);
        check_eq("acc_c3_we", ram_we_a, 0);
        check_eq("acc_c3_if_rdata", if_rdata_a, exp_if_rdata);
        check_eq("acc_c3_dm_rdata", dm_rdata_a, exp_dm_rdata);
        if_req = 0; dm_read = 0; dm_write = 0;
        next_cycle();
        check_eq("acc_c4_done", {if_done_a, dm_done_a}, 0);
        check_eq("acc_c4_dm_rdata", dm_rdata_a, exp_dm_rdata);
    endtask

    // IF and DM loads requested together in cycle 0; first_dm says who wins.
    task automatic contend(input logic first_dm, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] r1, input logic [31:0] r2);
        if_req = 1; dm_read = 1; if_addr = ia; dm_addr = da;
        settle();
        check_eq("cont_c0_if_stall", if_stall_a, 1);
        next_cycle();
        check_eq("cont_c1_addr", ram_addr_a, first_dm ? da : ia);
        next_cycle();
        ram_rdata = r1;
        next_cycle();
        check_eq("cont_c3_first_done", first_dm ? dm_done_a : if_done_a, 1);
        check_eq("cont_c3_other_done", first_dm ? if_done_a : dm_done_a, 0);
        check_eq("cont_c3_first_rdata", first_dm ? dm_rdata_a : if_rdata_a, r1);
        check_eq("cont_c3_other_stall", first_dm ? if_stall_a : dm_stall_a, 1);
        if (first_dm) dm_read = 0; else if_req = 0;
        next_cycle();
        check_eq("cont_c4_en", ram_en_a, 0);
        next_cycle();
        check_eq("cont_c5_en", ram_en_a, 1);
        check_eq("cont_c5_addr", ram_addr_a, first_dm ? ia : da);
        next_cycle();
        ram_rdata = r2;
        settle();
        check_eq("cont_c6_stall", first_dm ? if_stall_a : dm_stall_a, 1);
        next_cycle();
        check_eq("cont_c7_second_done", first_dm ? if_done_a : dm_done_a, 1);
        check_eq("cont_c7_second_rdata", first_dm ? if_rdata_a : dm_rdata_a, r2);
        check_eq("cont_c7_second_stall", first_dm ? if_stall_a : dm_stall_a, 0);
        if (first_dm) exp_if_rdata = r2; else exp_dm_rdata = r2;
        if (first_dm) exp_dm_rdata = r1; else exp_if_rdata = r1;
        if_req = 0; dm_read = 0;
        next_cycle();
    endtask

    initial begin
        rst = 1; if_req = 0; dm_read = 0; dm_write = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; ram_rdata = 0;
        exp_if_rdata = 0; exp_dm_rdata = 0;
        #12 rst = 0;
        next_cycle();
        check_eq("rst_ram_en", ram_en_a, 0);
        check_eq("rst_ram_we", ram_we_a, 0);
        check_eq("rst_ram_addr", ram_addr_a, 0);
        check_eq("rst_ram_wdata", ram_wdata_a, 0);
        check_eq("rst_rdata", if_rdata_a | dm_rdata_a, 0);
        check_eq("rst_done", {if_done_a, dm_done_a}, 0);
        check_eq("rst_stall", {if_stall_a, dm_stall_a}, 0);
        check_eq("rst_b_outs", {ram_en_b, ram_we_b, if_done_b, dm_done_b}, 0);
        next_cycle();
        check_eq("idle_ram_en", ram_en_a, 0);

        do_access(0, 0, 32'h40, 32'h0, 32'hDEADBEEF);
        do_access(0, 1, 32'h44, 32'h12345678, 32'h0BAD0BAD);
        // last grant was DM, so IF goes first.
        contend(0, 32'h200, 32'h300, 32'h11112222, 32'h33334444);

        // Fetch flushed in cycle 1; DM load arrives in cycle 2.
        if_req = 1; if_addr = 32'h500;
        next_cycle();
        if_req = 0;
        next_cycle();
        ram_rdata = 32'h55555555; dm_read = 1; dm_addr = 32'h600;
        settle();
        check_eq("flush_c2_if_stall", if_stall_a, 0);
        check_eq("flush_c2_en", ram_en_a, 1);
        next_cycle();
        check_eq("flush_c3_if_done", if_done_a, 1);
        check_eq("flush_c3_if_rdata", if_rdata_a, 32'h55555555);
        check_eq("flush_c3_dm_stall", dm_stall_a, 1);
        next_cycle();
        check_eq("flush_c4_en", ram_en_a, 0);
        next_cycle();
        check_eq("flush_c5_en", ram_en_a, 1);
        check_eq("flush_c5_addr", ram_addr_a, 32'h600);
        next_cycle();
        ram_rdata = 32'h66666666;
        next_cycle();
        check_eq("flush_c7_dm_done", dm_done_a, 1);
        check_eq("flush_c7_dm_rdata", dm_rdata_a, 32'h66666666);
        dm_read = 0;
        next_cycle();

        // Reset in the middle of a store.
        dm_write = 1; dm_addr = 32'h700; dm_wdata = 32'hA5A5A5A5;
        next_cycle();
        check_eq("rstw_we_before", ram_we_a, 1);
        #2 rst = 1;
        #1;
        check_eq("rstw_we_now", ram_we_a, 0);
        check_eq("rstw_en_now", ram_en_a, 0);
        check_eq("rstw_addr_now", ram_addr_a, 0);
        check_eq("rstw_rdata_now", if_rdata_a | dm_rdata_a, 0);
        dm_write = 0;
        #2 rst = 0;
        exp_if_rdata = 0; exp_dm_rdata = 0;
        next_cycle();
        check_eq("rstw_idle_en", ram_en_a, 0);
        check_eq("rstw_no_done", dm_done_a, 0);

        // last grant reset to IF, so DM goes first.
        contend(1, 32'h800, 32'h900, 32'hDDDD0001, 32'hEEEE0002);
        next_cycle();

        // LATENCY=1 back-to-back fetches.
        if_req = 1; if_addr = 32'h0; ram_rdata = 32'h0;
        next_cycle();
        ram_rdata = 32'hA0A0A0A0;
        settle();
        check_eq("l1_c1_en", ram_en_b, 1);
        check_eq("l1_c1_addr", ram_addr_b, 32'h0);
        next_cycle();
        check_eq("l1_c2_done", if_done_b, 1);
        check_eq("l1_c2_rdata", if_rdata_b, 32'hA0A0A0A0);
        check_eq("l1_c2_stall", if_stall_b, 0);
        check_eq("l1_c2_en", ram_en_b, 0);
        if_addr = 32'h4;
        next_cycle();
        check_eq("l1_c3_done", if_done_b, 0);
        check_eq("l1_c3_stall", if_stall_b, 1);
        check_eq("l1_c3_en", ram_en_b, 0);
        next_cycle();
        ram_rdata = 32'hB1B1B1B1;
        settle();
        check_eq("l1_c4_en", ram_en_b, 1);
        check_eq("l1_c4_addr", ram_addr_b, 32'h4);
        next_cycle();
        check_eq("l1_c5_done", if_done_b, 1);
        check_eq("l1_c5_rdata", if_rdata_b, 32'hB1B1B1B1);
        if_req = 0;
        next_cycle();
        check_eq("l1_c6_done", if_done_b, 0);
        check_eq("l1_c6_rdata_hold", if_rdata_b, 32'hB1B1B1B1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
